// File: rtl/mem_stage.sv
// Pipeline MEM stage: a two-state IDLE/WAIT handshake with data memory, feeding registered MEM/WB outputs.
// Optional macro MEM_TIMEOUT_EN adds a 255-cycle WAIT timeout; without it WAIT lasts until dmem_ack.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [4:0]  control_in,
    input  logic [31:0] pc_4_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  regdst_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        valid_out,
    output logic [2:0]  control_out,
    output logic [31:0] pc_4,
    output logic [31:0] data_mem,
    output logic [31:0] data_alu,
    output logic [4:0]  regdst_out,
    output logic        dmem_timeout,
    output logic        err_illegal
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]  state;
    logic [2:0]  lat_ctrl;
    logic [31:0] lat_pc4;
    logic [4:0]  lat_regdst;
    logic        mem_read;
    logic        mem_write;
    logic        mem_op;
    logic        timeout_fire;

    assign mem_read  = control_in[4];
    assign mem_write = control_in[3];
    assign mem_op    = mem_read ^ mem_write;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Counts completed WAIT cycles; 254 here means the 255th cycle is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (state == IDLE) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_fire = (state == WAIT) && (wait_cnt == 8'd254) && !dmem_ack;
`else
    assign timeout_fire = 1'b0;
`endif

    assign dmem_req = (state == WAIT);
    assign stall    = (state == IDLE) ? (valid_in && mem_op)
                                      : !(dmem_ack || timeout_fire);

    // The memory-side address/data/we registers double as the latched operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lat_ctrl     <= 3'b000;
            lat_pc4      <= 32'd0;
            lat_regdst   <= 5'd0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            valid_out    <= 1'b0;
            control_out  <= 3'b000;
            pc_4         <= 32'd0;
            data_mem     <= 32'd0;
            data_alu     <= 32'd0;
            regdst_out   <= 5'd0;
            dmem_timeout <= 1'b0;
            err_illegal  <= 1'b0;
        end else begin
            valid_out    <= 1'b0;
            control_out  <= 3'b000;
            dmem_timeout <= 1'b0;
            err_illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (mem_op) begin
                            dmem_addr  <= alu_result;
                            dmem_wdata <= store_data;
                            dmem_we    <= mem_write;
                            lat_ctrl   <= control_in[2:0];
                            lat_pc4    <= pc_4_in;
                            lat_regdst <= regdst_in;
                            state      <= WAIT;
                        end else if (mem_read && mem_write) begin
                            err_illegal <= 1'b1;
                        end else begin
                            valid_out   <= 1'b1;
                            control_out <= control_in[2:0];
                            pc_4        <= pc_4_in;
                            data_alu    <= alu_result;
                            regdst_out  <= regdst_in;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        valid_out   <= 1'b1;
                        control_out <= lat_ctrl;
                        pc_4        <= lat_pc4;
                        data_alu    <= dmem_addr;
                        regdst_out  <= lat_regdst;
                        if (!dmem_we) begin
                            data_mem <= dmem_rdata;
                        end
                        state <= IDLE;
                    end else if (timeout_fire) begin
                        dmem_timeout <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
